// File: rtl/abc_adder_pkg.sv
// Shared types for the adder arbiter: requester id and the in-flight pipe entry.
package abc_adder_pkg;

    localparam int TAG_W_DEF = 4;
    // Pipe entries carry the widest supported tag; the top narrows it back to TAG_W.
    localparam int TAG_MAX   = 16;

    typedef logic req_id_t;

    typedef struct packed {
        logic               valid;
        req_id_t            req_id;
        logic [TAG_MAX-1:0] tag;
    } pipe_entry_t;

endpackage

// File: rtl/abc_rsp_pipe.sv
// LAT-deep delay line that tracks which requester owns the sum emerging from the adder.
module abc_rsp_pipe
    import abc_adder_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  pipe_entry_t din,
    output pipe_entry_t dout,
    output logic        busy
);

    pipe_entry_t stg [LAT];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < LAT; i++) stg[i] <= '0;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
        end
    end

    assign dout = stg[LAT-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) busy = busy | stg[i].valid;
    end

endmodule

// File: rtl/abc_adder_arb.sv
// Two-requester round-robin arbiter in front of an external shared 3-input adder.
module abc_adder_arb
    import abc_adder_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r0_b,
    input  logic [31:0]      r0_c,
    input  logic             r0_cin,
    input  logic [TAG_W-1:0] r0_tag,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r1_b,
    input  logic [31:0]      r1_c,
    input  logic             r1_cin,
    input  logic [TAG_W-1:0] r1_tag,
    input  logic             flush,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic [31:0]      add_c,
    output logic             add_cin,
    input  logic [31:0]      add_s,
    output logic             rsp0_valid,
    output logic [31:0]      rsp0_s,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    output logic [31:0]      rsp1_s,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             busy
);

    req_id_t     prio;
    logic        gnt0, gnt1;
    logic        pipe_busy;
    pipe_entry_t din, dout;

    // Requester equal to prio wins a tie; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !flush) begin
            if (r0_valid && (!r1_valid || prio == 1'b0)) gnt0 = 1'b1;
            else if (r1_valid)                            gnt1 = 1'b1;
        end
    end

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    always_ff @(posedge clk) begin
        if (rst)       prio <= 1'b0;
        else if (gnt0) prio <= 1'b1;
        else if (gnt1) prio <= 1'b0;
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_c   = '0;
        add_cin = 1'b0;
        din     = '0;
        if (gnt0) begin
            add_a   = r0_a;
            add_b   = r0_b;
            add_c   = r0_c;
            add_cin = r0_cin;
            din     = '{valid: 1'b1, req_id: 1'b0, tag: TAG_MAX'(r0_tag)};
        end else if (gnt1) begin
            add_a   = r1_a;
            add_b   = r1_b;
            add_c   = r1_c;
            add_cin = r1_cin;
            din     = '{valid: 1'b1, req_id: 1'b1, tag: TAG_MAX'(r1_tag)};
        end
    end

    abc_rsp_pipe #(.LAT(LAT)) u_pipe (
        .clk  (clk),
        .clr  (rst || flush),
        .din  (din),
        .dout (dout),
        .busy (pipe_busy)
    );

    // Responses are masked during reset so a dropped op can never strobe out.
    always_comb begin
        rsp0_valid = !rst && dout.valid && (dout.req_id == 1'b0);
        rsp1_valid = !rst && dout.valid && (dout.req_id == 1'b1);
        rsp0_s     = rsp0_valid ? add_s : '0;
        rsp1_s     = rsp1_valid ? add_s : '0;
        rsp0_tag   = rsp0_valid ? TAG_W'(dout.tag) : '0;
        rsp1_tag   = rsp1_valid ? TAG_W'(dout.tag) : '0;
        busy       = !rst && pipe_busy;
    end

endmodule

// File: tb/tb_abc_adder_arb.sv
// Directed bench: two arbiter copies (LAT=1 and LAT=3) share stimulus, each with an adder model.
module tb_abc_adder_arb;

    logic        clk;
    logic        rst, flush;
    logic        r0_valid, r0_cin, r1_valid, r1_cin;
    logic [31:0] r0_a, r0_b, r0_c, r1_a, r1_b, r1_c;
    logic [3:0]  r0_tag, r1_tag;

    logic        d1_r0_ready, d1_r1_ready, d1_add_cin, d1_rsp0_valid, d1_rsp1_valid, d1_busy;
    logic [31:0] d1_add_a, d1_add_b, d1_add_c, d1_add_s, d1_rsp0_s, d1_rsp1_s;
    logic [3:0]  d1_rsp0_tag, d1_rsp1_tag;
    logic        d3_r0_ready, d3_r1_ready, d3_add_cin, d3_rsp0_valid, d3_rsp1_valid, d3_busy;
    logic [31:0] d3_add_a, d3_add_b, d3_add_c, d3_add_s, d3_rsp0_s, d3_rsp1_s;
    logic [3:0]  d3_rsp0_tag, d3_rsp1_tag;

    int nchk = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    abc_adder_arb #(.LAT(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(d1_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_c(r0_c),
        .r0_cin(r0_cin), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(d1_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_c(r1_c),
        .r1_cin(r1_cin), .r1_tag(r1_tag),
        .flush(flush),
        .add_a(d1_add_a), .add_b(d1_add_b), .add_c(d1_add_c), .add_cin(d1_add_cin), .add_s(d1_add_s),
        .rsp0_valid(d1_rsp0_valid), .rsp0_s(d1_rsp0_s), .rsp0_tag(d1_rsp0_tag),
        .rsp1_valid(d1_rsp1_valid), .rsp1_s(d1_rsp1_s), .rsp1_tag(d1_rsp1_tag),
        .busy(d1_busy)
    );

    abc_adder_arb #(.LAT(3), .TAG_W(4)) dut3 (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(d3_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_c(r0_c),
        .r0_cin(r0_cin), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(d3_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_c(r1_c),
        .r1_cin(r1_cin), .r1_tag(r1_tag),
        .flush(flush),
        .add_a(d3_add_a), .add_b(d3_add_b), .add_c(d3_add_c), .add_cin(d3_add_cin), .add_s(d3_add_s),
        .rsp0_valid(d3_rsp0_valid), .rsp0_s(d3_rsp0_s), .rsp0_tag(d3_rsp0_tag),
        .rsp1_valid(d3_rsp1_valid), .rsp1_s(d3_rsp1_s), .rsp1_tag(d3_rsp1_tag),
        .busy(d3_busy)
    );

    // External adder models: sum of the driven operands, delayed LAT cycles.
    logic [31:0] s1, p0, p1, p2;
    always_ff @(posedge clk) begin
        s1 <= d1_add_a + d1_add_b + d1_add_c + {31'b0, d1_add_cin};
        p0 <= d3_add_a + d3_add_b + d3_add_c + {31'b0, d3_add_cin};
        p1 <= p0;
        p2 <= p1;
    end
    assign d1_add_s = s1;
    assign d3_add_s = p2;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic cin, input logic [3:0] tag);
        r0_valid = v; r0_a = a; r0_b = b; r0_c = c; r0_cin = cin; r0_tag = tag;
    endtask

    task automatic set_r1(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic cin, input logic [3:0] tag);
        r1_valid = v; r1_a = a; r1_b = b; r1_c = c; r1_cin = cin; r1_tag = tag;
    endtask

    initial begin
        // Reset with both requesters asserting: nothing may be granted.
        rst = 1'b1; flush = 1'b0;
        set_r0(1'b1, 32'd4, 32'd4, 32'd4, 1'b1, 4'd1);
        set_r1(1'b1, 32'd8, 32'd8, 32'd8, 1'b1, 4'd2);
        #2;
        chk1("rst_r0_ready", d1_r0_ready, 1'b0);
        chk1("rst_r1_ready", d1_r1_ready, 1'b0);
        chk32("rst_add_a", d1_add_a, 32'd0);
        chk1("rst_add_cin", d1_add_cin, 1'b0);
        tick(); tick();
        rst = 1'b0;
        set_r0(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_r1(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        #2;
        chk1("post_rst_busy", d1_busy, 1'b0);
        chk1("post_rst_rsp0_valid", d1_rsp0_valid, 1'b0);
        chk32("post_rst_rsp0_s", d1_rsp0_s, 32'd0);
        chk32("post_rst_rsp1_tag", {28'b0, d1_rsp1_tag}, 32'd0);
        tick();

        // Single op from r0: 1+2+3+1 = 7.
        set_r0(1'b1, 32'd1, 32'd2, 32'd3, 1'b1, 4'd5);
        #2;
        chk1("single_r0_ready", d1_r0_ready, 1'b1);
        chk1("single_r1_ready", d1_r1_ready, 1'b0);
        chk1("single_d3_r0_ready", d3_r0_ready, 1'b1);
        chk1("single_d3_r1_ready", d3_r1_ready, 1'b0);
        chk32("single_add_a", d1_add_a, 32'd1);
        chk32("single_add_c", d1_add_c, 32'd3);
        tick();
        set_r0(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        #2;
        chk1("single_rsp0_valid", d1_rsp0_valid, 1'b1);
        chk32("single_rsp0_s", d1_rsp0_s, 32'd7);
        chk32("single_rsp0_tag", {28'b0, d1_rsp0_tag}, 32'd5);
        chk1("single_rsp1_valid", d1_rsp1_valid, 1'b0);
        chk1("single_d1_busy", d1_busy, 1'b1);
        chk1("single_d3_busy", d3_busy, 1'b1);
        chk1("single_d3_early", d3_rsp0_valid, 1'b0);
        tick();
        #2;
        chk1("single_rsp0_once", d1_rsp0_valid, 1'b0);
        chk32("single_rsp0_s_idle", d1_rsp0_s, 32'd0);
        tick();
        #2;
        chk1("lat3_rsp0_valid", d3_rsp0_valid, 1'b1);
        chk32("lat3_rsp0_s", d3_rsp0_s, 32'd7);
        chk32("lat3_rsp0_tag", {28'b0, d3_rsp0_tag}, 32'd5);
        tick();

        // Contention after a fresh reset: r0, r1, r0, r1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_r0(1'b1, 32'd10, 32'd0, 32'd0, 1'b0, 4'd1);
        set_r1(1'b1, 32'd20, 32'd1, 32'd0, 1'b1, 4'd2);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk1("rr_r0_ready", d1_r0_ready, (k % 2) == 0);
            chk1("rr_r1_ready", d1_r1_ready, (k % 2) == 1);
            if (k > 0) begin
                chk1("rr_rsp0_valid", d1_rsp0_valid, ((k - 1) % 2) == 0);
                chk1("rr_rsp1_valid", d1_rsp1_valid, ((k - 1) % 2) == 1);
                chk32("rr_rsp0_s", d1_rsp0_s, ((k - 1) % 2) == 0 ? 32'd10 : 32'd0);
                chk32("rr_rsp1_s", d1_rsp1_s, ((k - 1) % 2) == 1 ? 32'd22 : 32'd0);
            end
            if (k == 3) begin
                chk1("rr_d3_rsp0_valid", d3_rsp0_valid, 1'b1);
                chk32("rr_d3_rsp0_s", d3_rsp0_s, 32'd10);
                chk32("rr_d3_rsp0_tag", {28'b0, d3_rsp0_tag}, 32'd1);
            end
            tick();
        end
        set_r0(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_r1(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        #2;
        chk1("rr_last_rsp1_valid", d1_rsp1_valid, 1'b1);
        chk32("rr_last_rsp1_tag", {28'b0, d1_rsp1_tag}, 32'd2);
        chk1("rr_d3_rsp1_valid", d3_rsp1_valid, 1'b1);
        chk32("rr_d3_rsp1_s", d3_rsp1_s, 32'd22);
        chk32("rr_d3_rsp1_tag", {28'b0, d3_rsp1_tag}, 32'd2);
        tick(); tick(); tick();

        // Wrap: 3*0xFFFFFFFF + 1 mod 2^32 = 0xFFFFFFFE.
        set_r1(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd9);
        #2;
        chk1("wrap_r1_ready", d1_r1_ready, 1'b1);
        tick();
        set_r1(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        #2;
        chk1("wrap_rsp1_valid", d1_rsp1_valid, 1'b1);
        chk32("wrap_rsp1_s", d1_rsp1_s, 32'hFFFF_FFFE);
        chk32("wrap_rsp1_tag", {28'b0, d1_rsp1_tag}, 32'd9);
        chk1("wrap_rsp0_valid", d1_rsp0_valid, 1'b0);
        tick(); tick(); tick();

        // Grant at t, flush at t+1: LAT=3 copy must never answer.
        set_r0(1'b1, 32'd5, 32'd0, 32'd0, 1'b0, 4'd3);
        #2;
        chk1("flush_grant", d3_r0_ready, 1'b1);
        tick();
        set_r0(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        flush = 1'b1;
        #2;
        chk1("flush_busy_t1", d3_busy, 1'b1);
        tick();
        flush = 1'b0;
        #2;
        chk1("flush_busy_t2", d3_busy, 1'b0);
        tick();
        #2;
        chk1("flush_no_rsp0_t3", d3_rsp0_valid, 1'b0);
        chk1("flush_no_rsp1_t3", d3_rsp1_valid, 1'b0);
        tick();

        // Contention under flush: no grant, operands zero, prio (=1) kept.
        set_r0(1'b1, 32'd3, 32'd3, 32'd3, 1'b0, 4'd4);
        set_r1(1'b1, 32'd6, 32'd6, 32'd6, 1'b0, 4'd6);
        flush = 1'b1;
        #2;
        chk1("fl_r0_ready", d1_r0_ready, 1'b0);
        chk1("fl_r1_ready", d1_r1_ready, 1'b0);
        chk32("fl_add_a", d1_add_a, 32'd0);
        chk32("fl_add_b", d1_add_b, 32'd0);
        tick();
        flush = 1'b0;
        #2;
        chk1("fl_prio_r1_ready", d1_r1_ready, 1'b1);
        chk1("fl_prio_r0_ready", d1_r0_ready, 1'b0);
        chk32("fl_add_a_r1", d1_add_a, 32'd6);
        tick();
        set_r0(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_r1(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        tick(); tick(); tick();

        // Reset one cycle after a grant drops the op and restores prio=0.
        set_r0(1'b1, 32'd2, 32'd2, 32'd2, 1'b0, 4'd7);
        #2;
        chk1("mr_grant", d1_r0_ready, 1'b1);
        tick();
        set_r0(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        rst = 1'b1;
        #2;
        chk1("mr_no_rsp_d1", d1_rsp0_valid, 1'b0);
        tick();
        rst = 1'b0;
        set_r0(1'b1, 32'd1, 32'd1, 32'd1, 1'b0, 4'd8);
        set_r1(1'b1, 32'd1, 32'd1, 32'd1, 1'b0, 4'd9);
        #2;
        chk1("mr_busy_d3", d3_busy, 1'b0);
        chk1("mr_busy_d1", d1_busy, 1'b0);
        chk1("mr_r0_wins", d1_r0_ready, 1'b1);
        chk1("mr_r1_loses", d1_r1_ready, 1'b0);
        tick();
        set_r0(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        set_r1(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
        #2;
        chk1("mr_d3_no_stale_rsp", d3_rsp0_valid, 1'b0);
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
